// File: rtl/cpu_id_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_id_seq_pkg
// Shared definitions for the registered instruction-decode stage:
//   - default widths and return-stack depth
//   - opcode encoding of the instruction set, including CALL and RET
//   - JMP_MODE codes (ABS, BASE, RET) and IN_B_SEL codes (IMM, REGF, DMEM)
//   - decode FSM states and the control-strobe bundle
// ---------------------------------------------------------------------------
package cpu_id_seq_pkg;

    localparam int WIDTH_DEF          = 13;
    localparam int IWIDTH_DEF         = 5;
    localparam int REG_F_SEL_SIZE_DEF = 4;
    localparam int IN_B_SEL_SIZE_DEF  = 2;
    localparam int STACK_DEPTH_DEF    = 4;

    // Opcode field is INSTR[WIDTH-1:DW]; encodings not listed decode to NOP.
    typedef enum logic [4:0] {
        OP_RST  = 5'd0,
        OP_LD   = 5'd1,
        OP_ST   = 5'd2,
        OP_LDR  = 5'd3,
        OP_STR  = 5'd4,
        OP_BAR  = 5'd5,
        OP_JMP  = 5'd6,
        OP_JMPO = 5'd7,
        OP_XORR = 5'd8,
        OP_ORR  = 5'd9,
        OP_ANDR = 5'd10,
        OP_ADDR = 5'd11,
        OP_SUBR = 5'd12,
        OP_LDI  = 5'd13,
        OP_LDAR = 5'd14,
        OP_CALL = 5'd15,
        OP_RET  = 5'd16
    } opcode_e;

    localparam logic [1:0] JMP_ABS   = 2'b00;
    localparam logic [1:0] JMP_BASE  = 2'b01;
    localparam logic [1:0] JMP_RET   = 2'b10;

    localparam logic [1:0] IN_B_IMM  = 2'b00;
    localparam logic [1:0] IN_B_REGF = 2'b01;
    localparam logic [1:0] IN_B_DMEM = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_LDAR2 = 1'b1
    } state_e;

    typedef struct packed {
        logic cpu_rst;
        logic pc_ld;
        logic en_acc;
        logic en_reg_f;
        logic en_d_mem;
        logic d_mem_addr_mode;
        logic base_reg_ld;
    } strobe_t;

    // Register-to-ALU operations share the same decode (REG_F_SEL, B = REG_F).
    function automatic logic is_reg_alu_op(input logic [4:0] op);
        logic hit;
        hit = (op == OP_XORR) || (op == OP_ORR) || (op == OP_ANDR) ||
              (op == OP_ADDR) || (op == OP_SUBR);
        return hit;
    endfunction

endpackage

// File: rtl/cpu_id_seq_ret_stack.sv
// ---------------------------------------------------------------------------
// cpu_ret_stack
// Synchronous LIFO holding return addresses for CALL/RET.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : write din_i on top (ignored when full)
//   pop_i         : drop the top entry (ignored when empty)
//   clr_i         : empty the stack (wins over push/pop)
//   dout_o        : current top entry (valid when !empty_o)
//   full_o/empty_o: occupancy judged on the current pointer
// ---------------------------------------------------------------------------
module cpu_ret_stack
    import cpu_id_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Count has one extra bit so that DEPTH entries is distinguishable from 0.
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] top_s;

    assign top_s   = cnt_q[AW-1:0] - AW'(1);
    assign dout_o  = mem_q[top_s];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // Pointer update: clear, push or pop, judged on the pointer before the edge
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (push_i && !full_o) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage, written at the current pointer on a successful push
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o && !clr_i) begin
            mem_q[cnt_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/cpu_id_seq.sv
// ---------------------------------------------------------------------------
// cpu_id_seq
// Registered, handshaked instruction-decode stage. One instruction is
// accepted per instr_valid_i && instr_ready_o and its control bundle appears
// in the output register the next cycle, held until out_ready_i. LDAR issues
// two beats (EN_ACC 0 then 1); CALL/RET use an internal return-address stack.
// Ports:
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   instr_i, instr_pc_i           : instruction word and its address
//   instr_valid_i / instr_ready_o : upstream handshake
//   out_valid_o / out_ready_i     : downstream handshake
//   *_o strobes                   : control bundle, qualified by out_valid_o
//   alu_out_o                     : INSTR[WIDTH-2:DW]
//   imm/d_mem_addr/base_reg_data/base_reg_offset/ret_addr : operand fields
//   in_b_sel_o, reg_f_sel_o, jmp_mode_o : selects
//   stack_ovf_o, stack_unf_o      : sticky stack error flags
// ---------------------------------------------------------------------------
module cpu_id_seq
    import cpu_id_seq_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int IWIDTH         = IWIDTH_DEF,
    parameter int REG_F_SEL_SIZE = REG_F_SEL_SIZE_DEF,
    parameter int IN_B_SEL_SIZE  = IN_B_SEL_SIZE_DEF,
    parameter int STACK_DEPTH    = STACK_DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [WIDTH-1:0]          instr_i,
    input  logic [WIDTH-IWIDTH-1:0]   instr_pc_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      cpu_rst_o,
    output logic                      pc_ld_o,
    output logic                      en_acc_o,
    output logic                      en_reg_f_o,
    output logic                      en_d_mem_o,
    output logic                      d_mem_addr_mode_o,
    output logic                      base_reg_ld_o,
    output logic [IWIDTH-2:0]         alu_out_o,
    output logic [WIDTH-IWIDTH-1:0]   imm_o,
    output logic [WIDTH-IWIDTH-1:0]   d_mem_addr_o,
    output logic [WIDTH-IWIDTH-1:0]   base_reg_data_o,
    output logic [WIDTH-IWIDTH-1:0]   base_reg_offset_o,
    output logic [WIDTH-IWIDTH-1:0]   ret_addr_o,
    output logic [IN_B_SEL_SIZE-1:0]  in_b_sel_o,
    output logic [REG_F_SEL_SIZE-1:0] reg_f_sel_o,
    output logic [1:0]                jmp_mode_o,
    output logic                      stack_ovf_o,
    output logic                      stack_unf_o
);

    localparam int DW = WIDTH - IWIDTH;
    localparam logic [IN_B_SEL_SIZE-1:0] B_DMEM = IN_B_SEL_SIZE'(IN_B_DMEM);

    state_e                    state_q, state_d;
    logic                      out_valid_q, out_valid_d;
    strobe_t                   strb_q, strb_d;
    logic [IWIDTH-2:0]         alu_out_q, alu_out_d;
    logic [DW-1:0]             imm_q, imm_d;
    logic [DW-1:0]             dma_q, dma_d;
    logic [DW-1:0]             brd_q, brd_d;
    logic [DW-1:0]             bro_q, bro_d;
    logic [DW-1:0]             ret_q, ret_d;
    logic [IN_B_SEL_SIZE-1:0]  bsel_q, bsel_d;
    logic [REG_F_SEL_SIZE-1:0] rsel_q, rsel_d;
    logic [1:0]                jm_q, jm_d;
    logic                      ovf_q, ovf_d;
    logic                      unf_q, unf_d;

    logic [IWIDTH-1:0]         op_s;
    logic [DW-1:0]             opd_s;
    logic                      instr_ready_s;
    logic                      accept_s;
    logic                      push_s, pop_s, clr_s;
    logic [DW-1:0]             stk_dout_s;
    logic                      stk_full_s, stk_empty_s;

    assign op_s  = instr_i[WIDTH-1:DW];
    assign opd_s = instr_i[DW-1:0];

    // A new instruction may enter only when no LDAR beat 2 is pending and the
    // output register is free or being drained this cycle.
    assign instr_ready_s = rst_ni && (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
    assign accept_s      = instr_valid_i && instr_ready_s;

    cpu_ret_stack #(
        .DW    (DW),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .clr_i   (clr_s),
        .din_i   (instr_pc_i + DW'(1)),
        .dout_o  (stk_dout_s),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s)
    );

    // Next-state, next-bundle decode and stack control
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        strb_d      = strb_q;
        alu_out_d   = alu_out_q;
        imm_d       = imm_q;
        dma_d       = dma_q;
        brd_d       = brd_q;
        bro_d       = bro_q;
        ret_d       = ret_q;
        bsel_d      = bsel_q;
        rsel_d      = rsel_q;
        jm_d        = jm_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clr_s       = 1'b0;

        if (state_q == ST_LDAR2) begin
            // Beat 1 consumed: reload the same fields with the accumulator enabled.
            if (out_ready_i) begin
                strb_d.en_acc = 1'b1;
                out_valid_d   = 1'b1;
                state_d       = ST_IDLE;
            end else begin
                state_d = ST_LDAR2;
            end
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            strb_d      = '0;
            alu_out_d   = instr_i[WIDTH-2:DW];
            imm_d       = '0;
            dma_d       = '0;
            brd_d       = '0;
            bro_d       = '0;
            ret_d       = '0;
            bsel_d      = B_DMEM;
            rsel_d      = '0;
            jm_d        = JMP_ABS;
            case (op_s)
                IWIDTH'(OP_RST): begin
                    strb_d.cpu_rst = 1'b1;
                    clr_s          = 1'b1;
                end
                IWIDTH'(OP_LD): begin
                    dma_d         = opd_s;
                    strb_d.en_acc = 1'b1;
                end
                IWIDTH'(OP_ST): begin
                    dma_d           = opd_s;
                    strb_d.en_d_mem = 1'b1;
                end
                IWIDTH'(OP_LDR): begin
                    rsel_d        = instr_i[REG_F_SEL_SIZE-1:0];
                    bsel_d        = IN_B_SEL_SIZE'(IN_B_REGF);
                    strb_d.en_acc = 1'b1;
                end
                IWIDTH'(OP_STR): begin
                    rsel_d          = instr_i[REG_F_SEL_SIZE-1:0];
                    strb_d.en_reg_f = 1'b1;
                end
                IWIDTH'(OP_BAR): begin
                    brd_d              = opd_s;
                    strb_d.base_reg_ld = 1'b1;
                end
                IWIDTH'(OP_JMP): begin
                    bro_d        = opd_s;
                    strb_d.pc_ld = 1'b1;
                end
                IWIDTH'(OP_JMPO): begin
                    bro_d        = opd_s;
                    strb_d.pc_ld = 1'b1;
                    jm_d         = JMP_BASE;
                end
                IWIDTH'(OP_LDI): begin
                    imm_d         = opd_s;
                    bsel_d        = IN_B_SEL_SIZE'(IN_B_IMM);
                    strb_d.en_acc = 1'b1;
                end
                IWIDTH'(OP_LDAR): begin
                    rsel_d                 = instr_i[REG_F_SEL_SIZE-1:0];
                    strb_d.d_mem_addr_mode = 1'b1;
                    state_d                = ST_LDAR2;
                end
                IWIDTH'(OP_CALL): begin
                    // Full stack: keep the pointer, flag it and issue a NOP.
                    if (stk_full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s       = 1'b1;
                        bro_d        = opd_s;
                        strb_d.pc_ld = 1'b1;
                    end
                end
                IWIDTH'(OP_RET): begin
                    if (stk_empty_s) begin
                        unf_d = 1'b1;
                    end else begin
                        pop_s        = 1'b1;
                        ret_d        = stk_dout_s;
                        strb_d.pc_ld = 1'b1;
                        jm_d         = JMP_RET;
                    end
                end
                default: begin
                    if (is_reg_alu_op(5'(op_s))) begin
                        rsel_d = instr_i[REG_F_SEL_SIZE-1:0];
                        bsel_d = IN_B_SEL_SIZE'(IN_B_REGF);
                    end else begin
                        rsel_d = '0;
                    end
                end
            endcase
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output-bundle registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            strb_q      <= '0;
            alu_out_q   <= '0;
            imm_q       <= '0;
            dma_q       <= '0;
            brd_q       <= '0;
            bro_q       <= '0;
            ret_q       <= '0;
            bsel_q      <= B_DMEM;
            rsel_q      <= '0;
            jm_q        <= JMP_ABS;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            strb_q      <= strb_d;
            alu_out_q   <= alu_out_d;
            imm_q       <= imm_d;
            dma_q       <= dma_d;
            brd_q       <= brd_d;
            bro_q       <= bro_d;
            ret_q       <= ret_d;
            bsel_q      <= bsel_d;
            rsel_q      <= rsel_d;
            jm_q        <= jm_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign instr_ready_o     = instr_ready_s;
    assign out_valid_o       = out_valid_q;
    assign cpu_rst_o         = strb_q.cpu_rst;
    assign pc_ld_o           = strb_q.pc_ld;
    assign en_acc_o          = strb_q.en_acc;
    assign en_reg_f_o        = strb_q.en_reg_f;
    assign en_d_mem_o        = strb_q.en_d_mem;
    assign d_mem_addr_mode_o = strb_q.d_mem_addr_mode;
    assign base_reg_ld_o     = strb_q.base_reg_ld;
    assign alu_out_o         = alu_out_q;
    assign imm_o             = imm_q;
    assign d_mem_addr_o      = dma_q;
    assign base_reg_data_o   = brd_q;
    assign base_reg_offset_o = bro_q;
    assign ret_addr_o        = ret_q;
    assign in_b_sel_o        = bsel_q;
    assign reg_f_sel_o       = rsel_q;
    assign jmp_mode_o        = jm_q;
    assign stack_ovf_o       = ovf_q;
    assign stack_unf_o       = unf_q;

endmodule

// File: tb/tb_cpu_id_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_id_seq
// Self-checking bench for cpu_id_seq: a table of single-beat decodes, hand
// sequences for stalls, LDAR, CALL/RET and reset, and random traffic. A
// reference model keeps the expected output beats in a queue and the return
// stack in a second queue.
// ---------------------------------------------------------------------------
module tb_cpu_id_seq;
    import cpu_id_seq_pkg::*;

    localparam int DEPTH = 4;

    localparam logic [6:0] S_RST  = 7'b1000000;
    localparam logic [6:0] S_PCLD = 7'b0100000;
    localparam logic [6:0] S_ACC  = 7'b0010000;
    localparam logic [6:0] S_REGF = 7'b0001000;
    localparam logic [6:0] S_DMEM = 7'b0000100;
    localparam logic [6:0] S_MODE = 7'b0000010;
    localparam logic [6:0] S_BLD  = 7'b0000001;

    typedef struct packed {
        logic [6:0] strb;
        logic [3:0] alu;
        logic [7:0] imm;
        logic [7:0] dma;
        logic [7:0] brd;
        logic [7:0] bro;
        logic [7:0] ret;
        logic [1:0] bsel;
        logic [3:0] rsel;
        logic [1:0] jm;
    } bun_t;

    typedef struct {
        logic [12:0] ins;
        bun_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, instr_valid, instr_ready, out_valid, out_ready;
    logic [12:0] instr;
    logic [7:0]  instr_pc;
    logic        cpu_rst, pc_ld, en_acc, en_reg_f, en_d_mem, d_mem_addr_mode, base_reg_ld;
    logic [3:0]  alu_out;
    logic [7:0]  imm, d_mem_addr, base_reg_data, base_reg_offset, ret_addr;
    logic [1:0]  in_b_sel;
    logic [3:0]  reg_f_sel;
    logic [1:0]  jmp_mode;
    logic        stack_ovf, stack_unf;
    bun_t        act;

    always #5 clk = ~clk;

    cpu_id_seq dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .instr_i           (instr),
        .instr_pc_i        (instr_pc),
        .instr_valid_i     (instr_valid),
        .instr_ready_o     (instr_ready),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .cpu_rst_o         (cpu_rst),
        .pc_ld_o           (pc_ld),
        .en_acc_o          (en_acc),
        .en_reg_f_o        (en_reg_f),
        .en_d_mem_o        (en_d_mem),
        .d_mem_addr_mode_o (d_mem_addr_mode),
        .base_reg_ld_o     (base_reg_ld),
        .alu_out_o         (alu_out),
        .imm_o             (imm),
        .d_mem_addr_o      (d_mem_addr),
        .base_reg_data_o   (base_reg_data),
        .base_reg_offset_o (base_reg_offset),
        .ret_addr_o        (ret_addr),
        .in_b_sel_o        (in_b_sel),
        .reg_f_sel_o       (reg_f_sel),
        .jmp_mode_o        (jmp_mode),
        .stack_ovf_o       (stack_ovf),
        .stack_unf_o       (stack_unf)
    );

    assign act = {cpu_rst, pc_ld, en_acc, en_reg_f, en_d_mem, d_mem_addr_mode, base_reg_ld,
                  alu_out, imm, d_mem_addr, base_reg_data, base_reg_offset, ret_addr,
                  in_b_sel, reg_f_sel, jmp_mode};

    int         n_chk = 0;
    int         n_fail = 0;
    bun_t       sb[$];
    logic [7:0] stk[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    bun_t       rst_bun;
    vec_t       vt[12];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic bun_t mkb(input logic [6:0] s, input logic [1:0] bs, input logic [1:0] jm,
                                 input logic [3:0] rs, input logic [7:0] im, input logic [7:0] dm,
                                 input logic [7:0] bd, input logic [7:0] bo, input logic [3:0] al);
        bun_t b;
        b = '0;
        b.strb = s; b.bsel = bs; b.jm = jm; b.rsel = rs;
        b.imm = im; b.dma = dm; b.brd = bd; b.bro = bo; b.alu = al;
        return b;
    endfunction

    // Expected beat(s) for one accepted instruction, from the opcode rules.
    task automatic model_accept(input logic [12:0] ins, input logic [7:0] pc);
        bun_t       b;
        logic [7:0] opd;
        b = mkb(7'd0, 2'b10, 2'b00, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, ins[11:8]);
        opd = ins[7:0];
        case (ins[12:8])
            OP_RST:  begin b.strb = S_RST; stk.delete(); end
            OP_LD:   begin b.dma = opd; b.strb = S_ACC; end
            OP_ST:   begin b.dma = opd; b.strb = S_DMEM; end
            OP_LDR:  begin b.rsel = ins[3:0]; b.bsel = 2'b01; b.strb = S_ACC; end
            OP_STR:  begin b.rsel = ins[3:0]; b.strb = S_REGF; end
            OP_BAR:  begin b.brd = opd; b.strb = S_BLD; end
            OP_JMP:  begin b.bro = opd; b.strb = S_PCLD; end
            OP_JMPO: begin b.bro = opd; b.strb = S_PCLD; b.jm = 2'b01; end
            OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR: begin b.rsel = ins[3:0]; b.bsel = 2'b01; end
            OP_LDI:  begin b.imm = opd; b.bsel = 2'b00; b.strb = S_ACC; end
            OP_LDAR: begin
                b.rsel = ins[3:0]; b.strb = S_MODE;
                sb.push_back(b);
                b.strb = S_MODE | S_ACC;
            end
            OP_CALL: begin
                if (stk.size() == DEPTH) m_ovf = 1'b1;
                else begin stk.push_back(pc + 8'd1); b.strb = S_PCLD; b.bro = opd; end
            end
            OP_RET: begin
                if (stk.size() == 0) m_unf = 1'b1;
                else begin b.ret = stk.pop_back(); b.strb = S_PCLD; b.jm = 2'b10; end
            end
            default: ;
        endcase
        sb.push_back(b);
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check outputs at next negedge.
    task automatic tick(input logic rn, input logic v, input logic [12:0] ins,
                        input logic [7:0] pc, input logic ordy);
        logic m_ready;
        rst_n = rn; instr_valid = v; instr = ins; instr_pc = pc; out_ready = ordy;
        #1;
        m_ready = rn && ((sb.size() == 0) || ((sb.size() == 1) && ordy));
        chk("instr_ready", 64'(instr_ready), 64'(m_ready));
        @(posedge clk);
        if (!rn) begin
            sb.delete(); stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if ((sb.size() != 0) && ordy) void'(sb.pop_front());
            if (v && m_ready) model_accept(ins, pc);
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) chk("bundle", 64'(act), 64'(sb[0]));
        else if (!rn) chk("reset_bundle", 64'(act), 64'(rst_bun));
        chk("stack_ovf", 64'(stack_ovf), 64'(m_ovf));
        chk("stack_unf", 64'(stack_unf), 64'(m_unf));
    endtask

    initial begin
        logic [4:0]  rop;
        logic [12:0] rins;
        rst_bun = '0;
        rst_bun.bsel = 2'b10;

        vt[0]  = '{{OP_LD,   8'h10}, mkb(S_ACC,  2'b10, 2'b00, 4'h0, 8'h00, 8'h10, 8'h00, 8'h00, 4'h1)};
        vt[1]  = '{{OP_ST,   8'h11}, mkb(S_DMEM, 2'b10, 2'b00, 4'h0, 8'h00, 8'h11, 8'h00, 8'h00, 4'h2)};
        vt[2]  = '{{OP_LDR,  8'h35}, mkb(S_ACC,  2'b01, 2'b00, 4'h5, 8'h00, 8'h00, 8'h00, 8'h00, 4'h3)};
        vt[3]  = '{{OP_STR,  8'h0A}, mkb(S_REGF, 2'b10, 2'b00, 4'hA, 8'h00, 8'h00, 8'h00, 8'h00, 4'h4)};
        vt[4]  = '{{OP_BAR,  8'h77}, mkb(S_BLD,  2'b10, 2'b00, 4'h0, 8'h00, 8'h00, 8'h77, 8'h00, 4'h5)};
        vt[5]  = '{{OP_JMP,  8'h20}, mkb(S_PCLD, 2'b10, 2'b00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h20, 4'h6)};
        vt[6]  = '{{OP_JMPO, 8'h21}, mkb(S_PCLD, 2'b10, 2'b01, 4'h0, 8'h00, 8'h00, 8'h00, 8'h21, 4'h7)};
        vt[7]  = '{{OP_XORR, 8'h02}, mkb(7'd0,   2'b01, 2'b00, 4'h2, 8'h00, 8'h00, 8'h00, 8'h00, 4'h8)};
        vt[8]  = '{{OP_SUBR, 8'h07}, mkb(7'd0,   2'b01, 2'b00, 4'h7, 8'h00, 8'h00, 8'h00, 8'h00, 4'hC)};
        vt[9]  = '{{OP_LDI,  8'h5A}, mkb(S_ACC,  2'b00, 2'b00, 4'h0, 8'h5A, 8'h00, 8'h00, 8'h00, 4'hD)};
        vt[10] = '{{5'd31,   8'hFF}, mkb(7'd0,   2'b10, 2'b00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF)};
        vt[11] = '{{OP_RST,  8'h33}, mkb(S_RST,  2'b10, 2'b00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0)};

        // Reset held with a valid instruction waiting
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, {OP_LDI, 8'h5A}, 8'h00, 1'b1);
        tick(1'b1, 1'b1, {OP_LDI, 8'h5A}, 8'h00, 1'b1);
        chk("ldi_imm", 64'(imm), 64'(8'h5A));
        chk("ldi_bsel", 64'(in_b_sel), 64'(2'b00));
        chk("ldi_acc", 64'(en_acc), 64'(1'b1));
        tick(1'b1, 1'b0, 13'd0, 8'h00, 1'b1);

        // LD then ST with a three-cycle downstream stall
        tick(1'b1, 1'b1, {OP_LD, 8'h10}, 8'h01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, {OP_ST, 8'h11}, 8'h02, 1'b0);
            chk("stall_ld_held", 64'(d_mem_addr), 64'(8'h10));
        end
        tick(1'b1, 1'b1, {OP_ST, 8'h11}, 8'h02, 1'b1);
        chk("st_follows", 64'(en_d_mem), 64'(1'b1));
        tick(1'b1, 1'b0, 13'd0, 8'h00, 1'b1);

        // Single-beat decode table, one instruction per cycle
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, vt[i].ins, 8'(i), 1'b1);
            chk($sformatf("vec%0d", i), 64'(act), 64'(vt[i].exp));
        end
        tick(1'b1, 1'b0, 13'd0, 8'h00, 1'b1);

        // LDAR R3: two beats, upstream blocked for one cycle
        tick(1'b1, 1'b1, {OP_LDAR, 8'h03}, 8'h00, 1'b1);
        chk("ldar_b1_acc", 64'(en_acc), 64'(1'b0));
        chk("ldar_b1_mode", 64'(d_mem_addr_mode), 64'(1'b1));
        chk("ldar_b1_rsel", 64'(reg_f_sel), 64'(4'd3));
        tick(1'b1, 1'b1, {OP_LD, 8'h44}, 8'h00, 1'b1);
        chk("ldar_b2_acc", 64'(en_acc), 64'(1'b1));
        chk("ldar_b2_rsel", 64'(reg_f_sel), 64'(4'd3));
        tick(1'b1, 1'b0, 13'd0, 8'h00, 1'b1);

        // CALL 0x40 at PC 0x07, then RET
        tick(1'b1, 1'b1, {OP_CALL, 8'h40}, 8'h07, 1'b1);
        chk("call_pcld", 64'(pc_ld), 64'(1'b1));
        chk("call_off", 64'(base_reg_offset), 64'(8'h40));
        tick(1'b1, 1'b1, {OP_RET, 8'h00}, 8'h41, 1'b1);
        chk("ret_addr", 64'(ret_addr), 64'(8'h08));
        chk("ret_mode", 64'(jmp_mode), 64'(2'b10));

        // Overflow then underflow
        for (int i = 0; i <= DEPTH; i++) tick(1'b1, 1'b1, {OP_CALL, 8'h50}, 8'(8'h20 + i), 1'b1);
        chk("ovf_nop", 64'(pc_ld), 64'(1'b0));
        chk("ovf_flag", 64'(stack_ovf), 64'(1'b1));
        for (int i = 0; i <= DEPTH; i++) tick(1'b1, 1'b1, {OP_RET, 8'h00}, 8'h60, 1'b1);
        chk("unf_nop", 64'(pc_ld), 64'(1'b0));
        chk("unf_flag", 64'(stack_unf), 64'(1'b1));

        // Return address wraps
        tick(1'b1, 1'b1, {OP_CALL, 8'h12}, 8'hFF, 1'b1);
        tick(1'b1, 1'b1, {OP_RET, 8'h00}, 8'h12, 1'b1);
        chk("ret_wrap", 64'(ret_addr), 64'(8'h00));
        chk("ret_wrap_pcld", 64'(pc_ld), 64'(1'b1));

        // Reset during LDAR beat 1 (stalled): no beat 2 afterwards
        tick(1'b1, 1'b1, {OP_LDAR, 8'h05}, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 13'd0, 8'h00, 1'b0);
        chk("rst_ldar_flags", 64'({stack_ovf, stack_unf}), 64'(2'b00));
        tick(1'b1, 1'b0, 13'd0, 8'h00, 1'b1);
        chk("rst_no_beat2", 64'(out_valid), 64'(1'b0));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rop  = 5'($urandom_range(0, 19));
            rins = {rop, 8'($urandom)};
            tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rins,
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
